serial_adder_word_driver: RTL and testbench

Word-level front/back end for the bit-serial adder in this section. Accepts two W-bit operands over a valid/ready handshake and shifts them LSB-first into a serial adder as its `a`/`b` streams. It clears the adder's carry between words, collects the returned `sum` bits into a W-bit result, and offers that result downstream over a second valid/ready handshake. It sits between parallel logic and the serial adder instance, which it drives and reads.

---
 rtl/serial_adder_word_driver.sv | 108 ++++++++++
 tb/tb_serial_adder_word_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_word_driver.sv
// rtl/serial_adder_word_driver.sv - word-level driver/collector for a bit-serial adder
// Optional carry-out capture: define SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN.
module serial_adder_word_driver #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_a,
    input  logic [W-1:0] up_b,
    output logic         ser_clr,
    output logic         ser_a,
    output logic         ser_b,
    input  logic         ser_sum,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_carry
);

`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;
    logic [W-1:0]  sum_q;
    logic [CW-1:0] cnt;
`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
    logic          carry_q;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (up_valid) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(N - 1)) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sum_q <= '0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (up_valid) begin
                        sh_a  <= up_a;
                        sh_b  <= up_b;
                        sum_q <= '0;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
                        carry_q <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // Right shift back-fills zeros, so the extra carry cycle drives a=b=0.
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt < CW'(W))
                        sum_q <= {ser_sum, sum_q[W-1:1]};
`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
                    else
                        carry_q <= ser_sum;
`endif
                end
                default: ;
            endcase
        end
    end

    assign up_ready  = (state == IDLE);
    assign ser_clr   = (state != SHIFT);
    assign ser_a     = (state == SHIFT) & sh_a[0];
    assign ser_b     = (state == SHIFT) & sh_b[0];
    assign res_valid = (state == DONE);
    assign res_sum   = sum_q;
`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
    assign res_carry = carry_q;
`else
    assign res_carry = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_word_driver.sv
// tb/tb_serial_adder_word_driver.sv - directed bench for serial_adder_word_driver with a serial adder model
module tb_serial_adder_word_driver;

`ifdef SERIAL_ADDER_WORD_DRIVER_CARRY_OUT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif
    localparam int N8  = CE ? 9 : 8;
    localparam int N16 = CE ? 17 : 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       up_valid = 1'b0, up_ready, ser_clr, ser_a, ser_b, ser_sum;
    logic       res_valid, res_ready = 1'b0, res_carry;
    logic [7:0] up_a = '0, up_b = '0, res_sum;

    logic        up_valid16 = 1'b0, up_ready16, ser_clr16, ser_a16, ser_b16, ser_sum16;
    logic        res_valid16, res_ready16 = 1'b0, res_carry16;
    logic [15:0] up_a16 = '0, up_b16 = '0, res_sum16;

    serial_adder_word_driver #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_a(up_a), .up_b(up_b),
        .ser_clr(ser_clr), .ser_a(ser_a), .ser_b(ser_b), .ser_sum(ser_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_carry(res_carry)
    );

    serial_adder_word_driver #(.W(16)) dut16 (
        .clk(clk), .rst(rst),
        .up_valid(up_valid16), .up_ready(up_ready16), .up_a(up_a16), .up_b(up_b16),
        .ser_clr(ser_clr16), .ser_a(ser_a16), .ser_b(ser_b16), .ser_sum(ser_sum16),
        .res_valid(res_valid16), .res_ready(res_ready16), .res_sum(res_sum16), .res_carry(res_carry16)
    );

    // Serial adder models: combinational sum, carry register with synchronous clear.
    logic c8 = 1'b0, c16 = 1'b0;
    assign ser_sum   = ser_a ^ ser_b ^ c8;
    assign ser_sum16 = ser_a16 ^ ser_b16 ^ c16;
    always @(posedge clk) begin
        c8  <= ser_clr   ? 1'b0 : ((ser_a & ser_b) | (ser_a & c8) | (ser_b & c8));
        c16 <= ser_clr16 ? 1'b0 : ((ser_a16 & ser_b16) | (ser_a16 & c16) | (ser_b16 & c16));
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, " up_ready"}, up_ready, 1);
        check({tag, " ser_clr"}, ser_clr, 1);
        check({tag, " ser_a"}, ser_a, 0);
        check({tag, " ser_b"}, ser_b, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_sum"}, res_sum, 0);
        check({tag, " res_carry"}, res_carry, 0);
    endtask

    task automatic do_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                           input logic c, input string tag);
        int lat;
        logic [7:0] got_a, got_b;
        got_a = '0;
        got_b = '0;
        lat = 0;
        while (!up_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, " up_ready"}, up_ready, 1);
        up_a = a; up_b = b; up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0; up_a = ~a; up_b = ~b;
        lat = 0;
        while (!res_valid && lat < 50) begin
            if (lat < 8) begin got_a[lat] = ser_a; got_b[lat] = ser_b; end
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, lat, N8);
        check({tag, " ser_a stream"}, got_a, a);
        check({tag, " ser_b stream"}, got_b, b);
        check({tag, " res_sum"}, res_sum, s);
        check({tag, " res_carry"}, res_carry, CE ? c : 1'b0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, " up_ready after"}, up_ready, 1);
        check({tag, " res_valid after"}, res_valid, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    vec_t tv[6];

    initial begin
        int lat;
        tv[0] = '{8'h05, 8'h03, 8'h08, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        tv[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        tv[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tv[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        tv[5] = '{8'h3C, 8'hC3, 8'hFF, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            do_word(tv[i].a, tv[i].b, tv[i].sum, tv[i].carry, $sformatf("vec%0d", i));

        // Backpressure: hold res_ready low with up_valid pulses.
        up_a = 8'h21; up_b = 8'h13; up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check("hold latency", lat, N8);
        for (int k = 0; k < 5; k++) begin
            up_valid = k[0]; up_a = 8'hF0; up_b = 8'h0F;
            @(posedge clk); #1;
            check($sformatf("hold%0d res_sum", k), res_sum, 8'h34);
            check($sformatf("hold%0d res_valid", k), res_valid, 1);
            check($sformatf("hold%0d up_ready", k), up_ready, 0);
        end
        up_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("hold release up_ready", up_ready, 1);
        check("hold release res_valid", res_valid, 0);

        // Reset mid-SHIFT at shift cycle 3.
        up_a = 8'hAA; up_b = 8'h55; up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("pre-abort ser_clr", ser_clr, 0);
        check("pre-abort ser_a", ser_a, 1);
        check("pre-abort ser_b", ser_b, 0);
        rst = 1'b0;
        #1;
        check_reset_outs("abort");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort no result", res_valid, 0);
        do_word(8'h12, 8'h34, 8'h46, 1'b0, "post-abort");

        // Wide instance.
        up_a16 = 16'hFFFF; up_b16 = 16'hFFFF; up_valid16 = 1'b1;
        @(posedge clk); #1;
        up_valid16 = 1'b0;
        lat = 0;
        while (!res_valid16 && lat < 80) begin @(posedge clk); #1; lat++; end
        check("w16 latency", lat, N16);
        check("w16 res_sum", res_sum16, 16'hFFFE);
        check("w16 res_carry", res_carry16, CE ? 1 : 0);
        res_ready16 = 1'b1;
        @(posedge clk); #1;
        res_ready16 = 1'b0;
        check("w16 up_ready after", up_ready16, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
